// File: rtl/rst_sequencer.sv
// rst_sequencer: releases N_STAGES downstream resets one at a time, in index
// order. Each stage is held in reset for HOLD_CYC cycles, then released, and
// the sequencer waits for that stage's ready before moving to the next stage.
// A stage that never reports ready within TIMEOUT_CYC cycles puts every stage
// back into reset and raises a sticky error. All outputs come from flops.
module rst_sequencer #(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYC    = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                async_rst_i,
  input  logic                sw_rst_i,
  input  logic [N_STAGES-1:0] stage_rdy_i,
  output logic [N_STAGES-1:0] rst_o,
  output logic [2:0]          stage_o,
  output logic                done_o,
  output logic                err_o
);

  localparam logic [1:0] ST_HOLD     = 2'd0;
  localparam logic [1:0] ST_WAIT_RDY = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [1:0] ST_FAULT    = 2'd3;

  localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  IDX_LAST     = 3'(N_STAGES - 1);

  localparam logic [N_STAGES-1:0] RST_ALL = '1;

  logic [1:0]          state_q, state_d;
  logic [2:0]          idx_q,   idx_d;
  logic [15:0]         cnt_q,   cnt_d;
  logic [N_STAGES-1:0] rst_q,   rst_d;
  logic                done_q,  done_d;
  logic                err_q,   err_d;

  logic [N_STAGES-1:0] stage_mask;
  logic                rdy_sel;

  // Decode the current stage index into a one-hot mask and pick out only that
  // stage's ready bit; every other ready bit is deliberately ignored.
  always_comb begin
    stage_mask = '0;
    rdy_sel    = 1'b0;
    for (int k = 0; k < N_STAGES; k++) begin
      if (idx_q == 3'(k)) begin
        stage_mask[k] = 1'b1;
        rdy_sel       = stage_rdy_i[k];
      end
    end
  end

  // Next-state logic: soft reset overrides everything, otherwise hold a stage,
  // release it, wait for its ready, and either advance, finish, or time out.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    done_d  = done_q;
    err_d   = err_q;

    if (sw_rst_i) begin
      state_d = ST_HOLD;
      idx_d   = 3'd0;
      cnt_d   = 16'd0;
      rst_d   = RST_ALL;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_d   = rst_q & ~stage_mask;
            cnt_d   = 16'd0;
            state_d = ST_WAIT_RDY;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        ST_WAIT_RDY: begin
          if (rdy_sel) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 3'd1;
              cnt_d   = 16'd0;
              state_d = ST_HOLD;
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = ST_FAULT;
            err_d   = 1'b1;
            rst_d   = RST_ALL;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        ST_FAULT: begin
          state_d = ST_FAULT;
        end

        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  // State and output registers; the external reset puts every stage into
  // reset immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q <= ST_HOLD;
      idx_q   <= 3'd0;
      cnt_q   <= 16'd0;
      rst_q   <= RST_ALL;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rst_o   = rst_q;
  assign stage_o = idx_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with N_STAGES=3, HOLD_CYC=4, TIMEOUT_CYC=8.
// Edges are counted from the deassertion of async_rst_i; every expected value
// below is worked out by hand from the sequencing rules.
module tb_rst_sequencer;

  logic       clk;
  logic       async_rst_i;
  logic       sw_rst_i;
  logic [2:0] stage_rdy_i;
  logic [2:0] rst_o;
  logic [2:0] stage_o;
  logic       done_o;
  logic       err_o;

  int checks;
  int failures;
  int edge_cnt;
  bit inv_en;

  rst_sequencer #(
    .N_STAGES   (3),
    .HOLD_CYC   (4),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk        (clk),
    .async_rst_i(async_rst_i),
    .sw_rst_i   (sw_rst_i),
    .stage_rdy_i(stage_rdy_i),
    .rst_o      (rst_o),
    .stage_o    (stage_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic a_rst, input logic s_rst, input logic [2:0] rdy);
    async_rst_i = a_rst;
    sw_rst_i    = s_rst;
    stage_rdy_i = rdy;
  endtask

  // Packed compare of {rst_o, stage_o, done_o, err_o}.
  task automatic checkOutput(input string tag, input logic [2:0] exp_rst,
                             input logic [2:0] exp_stage, input logic exp_done,
                             input logic exp_err);
    logic [7:0] obs;
    logic [7:0] expv;
    obs  = {rst_o, stage_o, done_o, err_o};
    expv = {exp_rst, exp_stage, exp_done, exp_err};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s edge=%0d observed{rst,stage,done,err}=%b_%b_%b_%b expected=%b_%b_%b_%b",
             tag, edge_cnt, obs[7:5], obs[4:2], obs[1], obs[0],
             expv[7:5], expv[4:2], expv[1], expv[0]);
    end
  endtask

  // Advance to a given edge count and sample 1 time unit after it.
  task automatic goToEdge(input int target);
    while (edge_cnt < target) begin
      @(posedge clk);
      edge_cnt++;
    end
    #1;
  endtask

  // Deassert the external reset between clock edges and restart the count.
  task automatic releaseReset();
    @(posedge clk);
    #2;
    async_rst_i = 1'b0;
    edge_cnt    = 0;
  endtask

  function automatic bit thermOk(input logic [2:0] v);
    logic [2:0] inv;
    inv = ~v;
    return ((inv & (inv + 3'd1)) == 3'd0);
  endfunction

  // Every falling edge: outputs are X-free and rst_o keeps its thermometer shape.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      assert (!$isunknown({rst_o, stage_o, done_o, err_o})) else begin
        failures++;
        $error("[TB] FAIL no_x observed=%b_%b_%b_%b expected=known",
               rst_o, stage_o, done_o, err_o);
      end
      checks++;
      assert (thermOk(rst_o) === 1'b1) else begin
        failures++;
        $error("[TB] FAIL thermometer observed=%b expected=thermometer-coded", rst_o);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    edge_cnt = 0;
    inv_en   = 1'b0;

    // Nominal run with every ready bit already high.
    applyStimulus(1'b1, 1'b0, 3'b111);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 3'b111, 3'd0, 1'b0, 1'b0);
    inv_en = 1'b1;
    releaseReset();
    goToEdge(3);  checkOutput("nom_e3_hold",      3'b111, 3'd0, 1'b0, 1'b0);
    goToEdge(4);  checkOutput("nom_e4_rel0",      3'b110, 3'd0, 1'b0, 1'b0);
    goToEdge(5);  checkOutput("nom_e5_adv1",      3'b110, 3'd1, 1'b0, 1'b0);
    goToEdge(8);  checkOutput("nom_e8_hold1",     3'b110, 3'd1, 1'b0, 1'b0);
    goToEdge(9);  checkOutput("nom_e9_rel1",      3'b100, 3'd1, 1'b0, 1'b0);
    goToEdge(14); checkOutput("nom_e14_rel2",     3'b000, 3'd2, 1'b0, 1'b0);
    goToEdge(15); checkOutput("nom_e15_done",     3'b000, 3'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b000);
    goToEdge(20); checkOutput("nom_e20_done_sticky", 3'b000, 3'd2, 1'b1, 1'b0);

    // Soft reset held for three edges in DONE; counting restarts when it drops.
    applyStimulus(1'b0, 1'b1, 3'b111);
    goToEdge(21); checkOutput("sw_done_e21",      3'b111, 3'd0, 1'b0, 1'b0);
    goToEdge(23); checkOutput("sw_done_held_e23", 3'b111, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b111);
    goToEdge(26); checkOutput("sw_done_e26_hold", 3'b111, 3'd0, 1'b0, 1'b0);
    goToEdge(27); checkOutput("sw_done_e27_rel0", 3'b110, 3'd0, 1'b0, 1'b0);

    // Stage 0 ready arrives late; the other ready bits are high but ignored.
    applyStimulus(1'b1, 1'b0, 3'b110);
    #1;
    checkOutput("late_async_reset", 3'b111, 3'd0, 1'b0, 1'b0);
    releaseReset();
    goToEdge(4);  checkOutput("late_e4_rel0",     3'b110, 3'd0, 1'b0, 1'b0);
    goToEdge(7);  checkOutput("late_e7_waiting",  3'b110, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b111);
    goToEdge(8);  checkOutput("late_e8_adv1",     3'b110, 3'd1, 1'b0, 1'b0);
    goToEdge(11); checkOutput("late_e11_hold1",   3'b110, 3'd1, 1'b0, 1'b0);
    goToEdge(12); checkOutput("late_e12_rel1",    3'b100, 3'd1, 1'b0, 1'b0);
    goToEdge(17); checkOutput("late_e17_rel2",    3'b000, 3'd2, 1'b0, 1'b0);
    goToEdge(18); checkOutput("late_e18_done",    3'b000, 3'd2, 1'b1, 1'b0);

    // Stage 1 never becomes ready: timeout into FAULT, then soft reset.
    applyStimulus(1'b1, 1'b0, 3'b101);
    #1;
    releaseReset();
    goToEdge(9);  checkOutput("to_e9_rel1",       3'b100, 3'd1, 1'b0, 1'b0);
    goToEdge(16); checkOutput("to_e16_waiting",   3'b100, 3'd1, 1'b0, 1'b0);
    goToEdge(17); checkOutput("to_e17_fault",     3'b111, 3'd1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'b111);
    goToEdge(25); checkOutput("to_e25_fault_sticky", 3'b111, 3'd1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b111);
    goToEdge(26); checkOutput("sw_fault_e26",     3'b111, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b111);
    goToEdge(29); checkOutput("sw_fault_e29_hold", 3'b111, 3'd0, 1'b0, 1'b0);
    goToEdge(30); checkOutput("sw_fault_e30_rel0", 3'b110, 3'd0, 1'b0, 1'b0);

    // External reset pulsed between edges 10 and 11 aborts without a clock.
    applyStimulus(1'b1, 1'b0, 3'b111);
    #1;
    releaseReset();
    goToEdge(10); checkOutput("abort_e10",        3'b100, 3'd2, 1'b0, 1'b0);
    #2;
    async_rst_i = 1'b1;
    #1;
    checkOutput("abort_no_edge",    3'b111, 3'd0, 1'b0, 1'b0);
    #1;
    async_rst_i = 1'b0;
    edge_cnt    = 0;
    goToEdge(3);  checkOutput("rerun_e3_hold",    3'b111, 3'd0, 1'b0, 1'b0);
    goToEdge(4);  checkOutput("rerun_e4_rel0",    3'b110, 3'd0, 1'b0, 1'b0);
    goToEdge(14); checkOutput("rerun_e14_rel2",   3'b000, 3'd2, 1'b0, 1'b0);
    goToEdge(15); checkOutput("rerun_e15_done",   3'b000, 3'd2, 1'b1, 1'b0);

    inv_en = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter N_STAGES, default 3, number of sequenced reset outputs (legal 2..8).
REQ-002 SHALL have parameter HOLD_CYC, default 8, cycles each stage stays in reset before release (legal 1..65535).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 256, maximum cycles to wait for a stage ready (legal 1..65535).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port async_rst_i  input  1  reset, asynchronous, active-high; driven by the deassert-synchronized reset.
REQ-006 SHALL have port sw_rst_i  input  1  synchronous soft-reset request, active-high, level-sampled.
REQ-007 SHALL have port stage_rdy_i  input  N_STAGES  per-stage ready; bit k means stage k has come out of reset.
REQ-008 SHALL have port rst_o  output  N_STAGES  per-stage reset, active-high; bit k feeds stage k.
REQ-009 SHALL have port stage_o  output  3  index of the stage currently being sequenced.
REQ-010 SHALL have port done_o  output  1  all stages released and ready.
REQ-011 SHALL have port err_o  output  1  sticky ready-timeout fault.

Function
REQ-012 SHALL implement FSM states HOLD, WAIT_RDY, DONE, FAULT, plus stage index idx and a 16-bit cycle counter cnt.
REQ-013 SHALL register all outputs (no combinational path from inputs to outputs).
REQ-014 HOLD: cnt increments each edge; at the edge where cnt==HOLD_CYC-1, SHALL clear rst_o[idx], set cnt=0, enter WAIT_RDY.
REQ-015 WAIT_RDY: stage_rdy_i[idx]==1 with idx<N_STAGES-1 SHALL set idx+1, cnt=0, enter HOLD.
REQ-016 WAIT_RDY: stage_rdy_i[idx]==1 with idx==N_STAGES-1 SHALL enter DONE and set done_o=1 on the same edge.
REQ-017 WAIT_RDY: stage_rdy_i[idx]==0 SHALL increment cnt; at the edge where cnt==TIMEOUT_CYC-1, SHALL enter FAULT, set err_o=1, drive rst_o all ones.
REQ-018 stage_rdy_i SHALL be evaluated from the first WAIT_RDY cycle; rdy already high gives a one-cycle WAIT_RDY.
REQ-019 SHALL sample only stage_rdy_i[idx]; other bits ignored, and all bits ignored in DONE and FAULT.
REQ-020 rst_o SHALL stay thermometer-coded: rst_o[k]==0 implies rst_o[j]==0 for all j<k; released stages stay released until REQ-022/REQ-023.
REQ-021 stage_o SHALL equal idx; in DONE stage_o SHALL equal N_STAGES-1; in FAULT stage_o SHALL hold the failing index.
REQ-022 sw_rst_i==1 at an edge, in any state, SHALL take priority over all transitions: rst_o all ones, idx=0, cnt=0, done_o=0, err_o=0, state HOLD.
REQ-023 While sw_rst_i stays high, cnt SHALL remain 0; sequencing restarts on the first edge with sw_rst_i low.
REQ-024 FAULT and DONE SHALL be left only via sw_rst_i or async_rst_i.

Reset
REQ-025 async_rst_i high SHALL, without a clock edge, force state HOLD, idx=0, cnt=0, rst_o all ones, stage_o=0, done_o=0, err_o=0.
REQ-026 Assertion mid-sequence, in any state, SHALL abort immediately; after deassertion, rst_o[0] SHALL fall on the HOLD_CYC-th rising edge.
REQ-027 After DONE, stage k release-to-release spacing SHALL be HOLD_CYC+W cycles, where W is the WAIT_RDY cycle count (at least 1).

Verification (N_STAGES=3, HOLD_CYC=4, TIMEOUT_CYC=8; edges counted from async_rst_i deassertion)
REQ-028 Nominal, stage_rdy_i=3'b111 -> rst_o[0] falls at edge 4, rst_o[1] at edge 9, rst_o[2] at edge 14; done_o=1 at edge 15; err_o stays 0.
REQ-029 stage_rdy_i[0] rises 3 cycles after rst_o[0] falls -> rst_o[1] falls at edge 12, rst_o[2] at edge 17; done_o=1 at edge 18; no error.
REQ-030 stage_rdy_i[1] held 0 -> rst_o[1] falls at edge 9; FAULT at edge 17 with err_o=1, rst_o=3'b111, stage_o=1; stays there until reset.
REQ-031 async_rst_i pulsed between edges 10 and 11 -> rst_o=3'b111, done_o=0 before the next edge; full sequence re-runs from edge 4 after deassertion.
REQ-032 One-cycle sw_rst_i in DONE, and again in FAULT -> next edge rst_o=3'b111, done_o=0, err_o=0; rst_o[0] falls 4 edges after the sw_rst_i edge.
REQ-033 All scenarios: checker asserts the thermometer invariant on rst_o and the absence of X on every output every cycle.
